// File: rtl/dline_responder.sv
// Memory-side responder for data-cache line refills and writebacks.
// One transaction at a time: optional wait, four 32-bit beats, one-cycle ready pulse.
module dline_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         Dcache_rd_req_i,
   input  logic [31:0]  Dcache_rd_addr_i,
   input  logic         Dcache_wb_req_i,
   input  logic [31:0]  Dcache_wb_addr_i,
   input  logic [127:0] Dcache_wb_data_i,
   output logic [127:0] ram_data_o,
   output logic         ram_ready_o,
   output logic         ram_err_o,
   output logic         ram_busy_o
);

   localparam int unsigned AW     = $clog2(DEPTH_WORDS);
   localparam int unsigned LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_op_wb;
   logic           r_range;
   logic [AW-1:0]  r_word_base;
   logic [127:0]   r_wb_data;
   logic [3:0]     r_cnt;
   logic [1:0]     r_beat;
   logic [31:0]    r_mem [DEPTH_WORDS];

   logic           w_accept;
   logic [31:0]    w_addr;
   logic [31:0]    w_offset;
   logic [AW-1:0]  w_idx;
   logic [6:0]     w_lane;
   logic           w_busy_d;
   logic           w_ready_d;
   logic           w_err_d;

   // Writeback has priority so a victim lands before its refill
   assign w_accept = (r_state == S_IDLE) && (Dcache_wb_req_i || Dcache_rd_req_i);
   assign w_addr   = Dcache_wb_req_i ? Dcache_wb_addr_i : Dcache_rd_addr_i;
   assign w_offset = w_addr - BASE_ADDR;
   assign w_idx    = r_word_base | AW'(r_beat);
   assign w_lane   = {r_beat, 5'd0};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = (LATENCY > 0) ? S_WAIT : S_BEAT;
         S_WAIT:  if (r_cnt == 4'd0) w_next = S_BEAT;
         S_BEAT:  if (r_beat == 2'd3) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it
   always_comb begin
      w_busy_d  = (w_next != S_IDLE);
      w_ready_d = (w_next == S_DONE);
      w_err_d   = (w_next == S_DONE) && r_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_ready_o <= 1'b0;
         ram_err_o   <= 1'b0;
         ram_busy_o  <= 1'b0;
         ram_data_o  <= 128'd0;
         r_op_wb     <= 1'b0;
         r_range     <= 1'b0;
         r_word_base <= '0;
         r_wb_data   <= 128'd0;
         r_cnt       <= 4'd0;
         r_beat      <= 2'd0;
      end else begin
         ram_ready_o <= w_ready_d;
         ram_err_o   <= w_err_d;
         ram_busy_o  <= w_busy_d;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op_wb     <= Dcache_wb_req_i;
                  r_range     <= (w_offset >= SPAN);
                  r_word_base <= AW'(w_offset >> 2) & ~AW'(3);
                  r_cnt       <= 4'(LAT_M1);
                  r_beat      <= 2'd0;
                  if (Dcache_wb_req_i) r_wb_data <= Dcache_wb_data_i;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            end
            S_BEAT: begin
               r_beat <= r_beat + 2'd1;
               if (!r_op_wb) ram_data_o[w_lane +: 32] <= r_range ? 32'd0 : r_mem[w_idx];
            end
            default: ;
         endcase
      end
   end

   // Array is not reset; a beat in flight when reset arrives still commits
   always_ff @(posedge clk) begin
      if ((r_state == S_BEAT) && r_op_wb && !r_range) r_mem[w_idx] <= r_wb_data[w_lane +: 32];
   end

endmodule

// File: tb/tb_dline_responder.sv
// Bench for dline_responder: directed and random line transfers against a word-array model.
module tb_dline_responder;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         rd_req, wb_req;
   logic [31:0]  rd_addr, wb_addr;
   logic [127:0] wb_data;
   logic [127:0] data_o;
   logic         ready_o, err_o, busy_o;

   logic         rd_req0;
   logic [31:0]  rd_addr0;
   logic         wb_req0;
   logic [31:0]  wb_addr0;
   logic [127:0] wb_data0;
   logic [127:0] data0;
   logic         ready0, err0, busy0;

   int           checks = 0;
   int           passes = 0;
   logic [31:0]  m_mem [DEPTH];
   logic [127:0] hold_line;

   dline_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .Dcache_rd_req_i(rd_req), .Dcache_rd_addr_i(rd_addr),
      .Dcache_wb_req_i(wb_req), .Dcache_wb_addr_i(wb_addr), .Dcache_wb_data_i(wb_data),
      .ram_data_o(data_o), .ram_ready_o(ready_o), .ram_err_o(err_o), .ram_busy_o(busy_o)
   );

   dline_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .Dcache_rd_req_i(rd_req0), .Dcache_rd_addr_i(rd_addr0),
      .Dcache_wb_req_i(wb_req0), .Dcache_wb_addr_i(wb_addr0), .Dcache_wb_data_i(wb_data0),
      .ram_data_o(data0), .ram_ready_o(ready0), .ram_err_o(err0), .ram_busy_o(busy0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit out_of_range(input logic [31:0] a);
      return (a - BASE) >= 32'(DEPTH * 4);
   endfunction

   function automatic int line_of(input logic [31:0] a);
      return int'(((a - BASE) / 32'd16) % 32'(DEPTH / 4));
   endfunction

   function automatic logic [127:0] model_line(input int l);
      return {m_mem[4*l+3], m_mem[4*l+2], m_mem[4*l+1], m_mem[4*l]};
   endfunction

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One held-request transaction; starts and ends on a falling edge with the DUT idle
   task automatic run_txn(input bit wb, input logic [31:0] addr, input logic [127:0] wd, input string tag);
      int n;
      bit got;
      bit e;
      e = out_of_range(addr);
      if (wb) begin wb_req = 1'b1; wb_addr = addr; wb_data = wd; end
      else    begin rd_req = 1'b1; rd_addr = addr; end
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (ready_o) got = 1'b1;
      end
      wb_req = 1'b0;
      rd_req = 1'b0;
      chk({tag, " latency"}, 128'(n), 128'(LAT + 5));
      chk({tag, " err"}, 128'(err_o), 128'(e));
      if (!wb) hold_line = e ? 128'd0 : model_line(line_of(addr));
      else if (!e) for (int k = 0; k < 4; k++) m_mem[4*line_of(addr)+k] = wd[32*k +: 32];
      chk({tag, " data"}, data_o, hold_line);
      @(negedge clk);
   endtask

   initial begin
      logic [127:0] d;
      logic [31:0]  a;
      int n1, n2, pulses;
      int t0 [3];

      rst = 1'b1;
      rd_req = 1'b0; wb_req = 1'b0; rd_addr = '0; wb_addr = '0; wb_data = '0;
      rd_req0 = 1'b0; wb_req0 = 1'b0; rd_addr0 = '0; wb_addr0 = '0; wb_data0 = '0;
      hold_line = 128'd0;
      repeat (3) @(negedge clk);
      chk("reset busy", 128'(busy_o), 128'd0);
      chk("reset ready", 128'(ready_o), 128'd0);
      chk("reset err", 128'(err_o), 128'd0);
      chk("reset data", data_o, 128'd0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(1'b1, 32'h1000_0010, 128'h44444444_33333333_22222222_11111111, "wb line1");
      run_txn(1'b0, 32'h1000_001C, 128'd0, "rd line1");
      chk("rd line1 value", data_o, 128'h44444444_33333333_22222222_11111111);

      foreach (t0[i]) t0[i] = 0;
      for (int l = 0; l < 8; l++)
         if (l != 1) run_txn(1'b1, BASE + 32'(16 * l), rand_line(), "warmup wb");

      // Simultaneous writeback and refill of the same line
      d = rand_line();
      a = BASE + 32'h30 + 32'($urandom_range(0, 15));
      wb_req = 1'b1; wb_addr = a; wb_data = d; rd_req = 1'b1; rd_addr = a;
      n1 = 0; n2 = 0; pulses = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (ready_o) begin
            pulses++;
            if (pulses == 1) begin
               n1 = n; wb_req = 1'b0;
               chk("both first is wb", data_o, hold_line);
            end else if (pulses == 2) begin
               n2 = n; rd_req = 1'b0;
               chk("both rd data", data_o, d);
            end
         end
      end
      rd_req = 1'b0; wb_req = 1'b0;
      for (int k = 0; k < 4; k++) m_mem[12+k] = d[32*k +: 32];
      hold_line = d;
      chk("both pulses", 128'(pulses), 128'd2);
      chk("both wb latency", 128'(n1), 128'(LAT + 5));
      chk("both rd latency", 128'(n2), 128'(2 * LAT + 11));

      run_txn(1'b1, BASE + 32'hFF0, rand_line(), "wb last");
      run_txn(1'b0, BASE + 32'hFF8, 128'd0, "rd last");
      run_txn(1'b0, BASE, 128'd0, "rd line0 alias");

      run_txn(1'b0, 32'h0FFF_FFF0, 128'd0, "rd below base");
      run_txn(1'b0, BASE + 32'(DEPTH * 4), 128'd0, "rd above top");
      run_txn(1'b1, 32'h0FFF_FFF0, rand_line(), "wb below base");
      run_txn(1'b1, BASE + 32'(DEPTH * 4), rand_line(), "wb above top");
      run_txn(1'b0, BASE, 128'd0, "reread line0");
      run_txn(1'b0, BASE + 32'hFF0, 128'd0, "reread last");

      // Reset in beat 1 of a writeback to line 2
      d = rand_line();
      wb_req = 1'b1; wb_addr = BASE + 32'h20; wb_data = d;
      repeat (4) @(negedge clk);
      chk("pre-reset busy", 128'(busy_o), 128'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst busy", 128'(busy_o), 128'd0);
      chk("rst ready", 128'(ready_o), 128'd0);
      chk("rst data", data_o, 128'd0);
      rst = 1'b0; wb_req = 1'b0;
      hold_line = 128'd0;
      m_mem[8] = d[31:0];
      m_mem[9] = d[63:32];
      @(negedge clk);
      run_txn(1'b0, BASE + 32'h24, 128'd0, "rd after reset");

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
            1:       a = BASE - 32'($urandom_range(1, 4096));
            default: a = BASE + 32'(16 * $urandom_range(0, 7)) + 32'($urandom_range(0, 15));
         endcase
         run_txn(1'($urandom_range(0, 1)), a, rand_line(), "random");
      end

      // Zero-latency build with a held refill request
      rd_req0 = 1'b1; rd_addr0 = BASE;
      pulses = 0;
      for (int n = 1; n <= 19; n++) begin
         @(negedge clk);
         if (ready0) begin
            if (pulses < 3) t0[pulses] = n;
            pulses++;
            chk("lat0 err", 128'(err0), 128'd0);
         end
      end
      rd_req0 = 1'b0;
      chk("lat0 pulses", 128'(pulses), 128'd3);
      chk("lat0 first", 128'(t0[0]), 128'd5);
      chk("lat0 second", 128'(t0[1]), 128'd11);
      chk("lat0 third", 128'(t0[2]), 128'd17);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dline_responder.md
# dline_responder

Memory-side responder for the data-cache line interface. The core's data cache issues 128-bit line refills (`rd`) and dirty-line writebacks (`wb`); this block accepts one transaction at a time and services it against a 32-bit-wide word array, four beats per line, after a programmable access latency. It maps the core's data window at `BASE_ADDR` internally, so the top level connects the core's raw addresses to it. Completion is signalled by a one-cycle ready pulse.

## Interface
- `BASE_ADDR`, 32'h1000_0000: byte address of array word 0.
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two, at least 4.
- `LATENCY`, 2: wait cycles inserted before the first beat; 0 to 15.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `Dcache_rd_req_i` in 1: refill request, level; held until `ram_ready_o` is sampled.
- `Dcache_rd_addr_i` in 32: refill byte address; bits [3:0] are ignored.
- `Dcache_wb_req_i` in 1: writeback request, level; held until `ram_ready_o` is sampled.
- `Dcache_wb_addr_i` in 32: writeback byte address; bits [3:0] are ignored.
- `Dcache_wb_data_i` in 128: writeback line; word k is bits [32k+31:32k].
- `ram_data_o` out 128: refill line; holds its value until the next refill completes.
- `ram_ready_o` out 1: one-cycle completion pulse.
- `ram_err_o` out 1: asserted together with `ram_ready_o` when the address was out of range.
- `ram_busy_o` out 1: high in every state except IDLE.

## Operation
- States: IDLE, WAIT, BEAT, DONE.
- IDLE: samples the request inputs.
  - If `wb_req` is set, latch `wb_addr` and `wb_data`, set op=WB.
  - Else if `rd_req` is set, latch `rd_addr`, set op=RD.
  - Writeback wins when both are set, so a victim reaches memory before its refill.
  - Next state is WAIT if `LATENCY`>0, otherwise BEAT.
- WAIT: counter loads `LATENCY-1` on entry and decrements each cycle; moves to BEAT on the cycle it reads 0.
- BEAT: 2-bit beat counter k runs 0..3, one beat per cycle.
  - Word index = ((addr - `BASE_ADDR`) >> 2), with bits [1:0] replaced by k, modulo `DEPTH_WORDS`.
  - RD: `ram_data_o[32k+31:32k]` <= array[index].
  - WB: array[index] <= latched data word k.
  - After k=3, go to DONE.
- DONE: `ram_ready_o`=1 and `ram_err_o`=range flag for exactly this cycle; next state is IDLE.
- Range flag: set when (addr - `BASE_ADDR`), as unsigned 32-bit, is at least `DEPTH_WORDS`*4. Addresses below base wrap to large values and are flagged.
  - Flagged RD: all four beats write 0 into `ram_data_o`.
  - Flagged WB: array writes are suppressed.
  - The transaction still takes full latency and still pulses ready.
- Request handshake: the initiator drops the completed request in the cycle after ready. The IDLE cycle that follows DONE therefore sees the dropped request, so a request that is still pending (e.g. the refill behind a writeback) starts a new transaction there.
- Address and data inputs are ignored outside IDLE.
- Array contents are not initialised or cleared by reset.

## Timing
- Reset values: state IDLE, `ram_data_o`=0, `ram_ready_o`=0, `ram_err_o`=0, `ram_busy_o`=0, counters 0.
- Request first high in IDLE at cycle 0: `ram_ready_o` is high in cycle `LATENCY`+5.
  - Cycle 0: IDLE accepts.
  - `LATENCY` WAIT cycles.
  - 4 BEAT cycles.
  - DONE.
- Throughput: one line per `LATENCY`+6 cycles, including the mandatory IDLE.
- `ram_data_o` lane k is updated at the end of beat k. The full line is stable from the DONE cycle onward.
- A writeback is visible to a refill accepted in any later IDLE.
- `rst` high in any state: next cycle all outputs are at reset values and the transaction in flight is dropped.
  - A writeback that is partly done leaves its completed beats written.
  - No ready pulse is produced for the dropped transaction.
- `LATENCY`=0: IDLE goes directly to BEAT; ready arrives in cycle 5.

## Test plan
- Reset, then WB of 0x44444444_33333333_22222222_11111111 to 0x1000_0010 with `LATENCY`=2:
  - ready in cycle 7, err=0.
  - Then RD of 0x1000_001C returns the same line, ready 7 cycles after the RD request.
- Assert `rd_req` and `wb_req` together on the same line, both held until their own ready:
  - The WB completes first.
  - The RD starts in the IDLE after DONE and returns the written data.
  - Exactly two ready pulses are observed.
- RD at 0x0FFF_FFF0 and at `BASE_ADDR`+`DEPTH_WORDS`*4:
  - Ready with err=1 and `ram_data_o`=0.
  - A WB to the same addresses leaves array contents unchanged, verified by a reread of line 0.
- Last line of the array, `BASE_ADDR`+0xFF0 with depth 1024: WB then RD round-trips; err=0; no write aliases to line 0.
- Assert `rst` during beat k=1 of a WB:
  - Next cycle busy=0, ready=0, data=0.
  - A following RD of the line returns new words 0..1 and old words 2..3.
- `LATENCY`=0 build: RD returns ready in cycle 5; back-to-back held requests complete every 6 cycles.
